// File: rtl/clock_select_pkg.sv
// ============================================================================
// Module      : clock_select_pkg
// Description : Shared types and constants for the clock-select sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_select_pkg;

    localparam int SETTINGS_W    = 3;

    // Bit positions inside the select word driven to the clock mux stage
    localparam int SEL_HS2       = 0;
    localparam int SEL_PLL2      = 1;
    localparam int SEL_PLL2_ORIG = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRE    = 2'd1,
        ST_SETTLE = 2'd2
    } clksel_state_e;

endpackage

`default_nettype wire

// File: rtl/clksel_alive_sync.sv
// ============================================================================
// Module      : clksel_alive_sync
// Description : 2-FF synchronizer, edge detect and saturating edge counter
//               for the divided-down ext-clock toggle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clksel_alive_sync #(
    parameter int unsigned ALIVE_EDGES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic toggle_i,
    input  logic count_en_i,
    output logic edges_met_o
);

    localparam int unsigned       c_EW    = $clog2(ALIVE_EDGES + 1);
    localparam logic [c_EW-1:0]   c_EDGES = c_EW'(ALIVE_EDGES);

    logic [2:0]      sync_q;
    logic [c_EW-1:0] edge_cnt_q;
    logic [c_EW-1:0] edge_cnt_d;
    logic            edge_seen;

    // sync_q[1:0] is the synchronizer pair, sync_q[2] the edge-detect history
    assign edge_seen   = sync_q[1] ^ sync_q[2];
    assign edges_met_o = (edge_cnt_q == c_EDGES);

    always_comb begin
        edge_cnt_d = '0;
        if (count_en_i) begin
            edge_cnt_d = edge_cnt_q;
            if (edge_seen && !edges_met_o) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            edge_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[1:0], toggle_i};
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clock_select_ctrl.sv
// ============================================================================
// Module      : clock_select_ctrl
// Description : Glitch-safe clock-select sequencer: holds target reset around
//               every select change, buffers one pending request.
//               Optional ext-clock alive check: define CLKSEL_ALIVE_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_select_ctrl
    import clock_select_pkg::*;
#(
    parameter int unsigned           PRE_CYCLES     = 16,
    parameter int unsigned           SETTLE_CYCLES  = 1024,
    parameter logic [SETTINGS_W-1:0] RESET_SETTINGS = 3'b000,
`ifdef CLKSEL_ALIVE_CHECK_EN
    parameter int unsigned           ALIVE_EDGES    = 4,
    parameter int unsigned           ALIVE_TIMEOUT  = 65535,
`endif
    parameter int unsigned           CNT_WIDTH      = 16
) (
    input  logic                  usb_clk,
    input  logic                  reset,
    input  logic                  I_settings_wr,
    input  logic [SETTINGS_W-1:0] I_settings_data,
    input  logic                  I_clear,
`ifdef CLKSEL_ALIVE_CHECK_EN
    input  logic                  I_ext_clk_toggle,
    output logic                  O_alive_timeout,
`endif
    output logic [SETTINGS_W-1:0] O_clock_settings,
    output logic                  O_target_reset,
    output logic                  O_busy,
    output logic                  O_overrun,
    output logic [CNT_WIDTH-1:0]  O_switch_count
);

    localparam int unsigned     c_MAX_CYC     = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned     c_CW          = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CW-1:0] c_PRE_LAST    = c_CW'(PRE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);

    clksel_state_e         state_q, state_d;
    logic [c_CW-1:0]       cnt_q, cnt_d;
    logic [SETTINGS_W-1:0] settings_q, settings_d;
    logic [SETTINGS_W-1:0] target_q, target_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [SETTINGS_W-1:0] pend_data_q, pend_data_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  boot_q, boot_d;
    logic [SETTINGS_W-1:0] req_data;
    logic                  settle_exit;

    assign req_data = I_settings_wr ? I_settings_data : pend_data_q;

`ifdef CLKSEL_ALIVE_CHECK_EN
    localparam int unsigned     c_TW       = $clog2(ALIVE_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(ALIVE_TIMEOUT - 1);

    logic [c_TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            alive_to_q, alive_to_d;
    logic            edges_met;
    logic            tmo_hit;

    clksel_alive_sync #(
        .ALIVE_EDGES (ALIVE_EDGES)
    ) u_alive_sync (
        .clk         (usb_clk),
        .rst         (reset),
        .toggle_i    (I_ext_clk_toggle),
        .count_en_i  (state_q == ST_SETTLE),
        .edges_met_o (edges_met)
    );

    // A dead ext clock must not wedge the sequencer: timeout also releases SETTLE
    assign tmo_hit     = (tmo_cnt_q == c_TMO_LAST);
    assign settle_exit = (cnt_q == c_SETTLE_LAST) && (edges_met || tmo_hit);

    always_comb begin
        tmo_cnt_d  = '0;
        alive_to_d = alive_to_q;
        if (state_q == ST_SETTLE) begin
            tmo_cnt_d = tmo_hit ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
        if (I_clear) begin
            alive_to_d = 1'b0;
        end
        if ((state_q == ST_SETTLE) && tmo_hit && !edges_met) begin
            alive_to_d = 1'b1;
        end
    end

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            alive_to_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            alive_to_q <= alive_to_d;
        end
    end

    assign O_alive_timeout = alive_to_q;
`else
    assign settle_exit = (cnt_q == c_SETTLE_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        settings_d  = settings_q;
        target_d    = target_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        overrun_d   = overrun_q;
        count_d     = count_q;
        boot_d      = boot_q;

        if (I_clear) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (I_settings_wr || pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    if (req_data != settings_q) begin
                        target_d = req_data;
                        state_d  = ST_PRE;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == c_PRE_LAST) begin
                    cnt_d      = '0;
                    settings_d = target_q;
                    state_d    = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_exit) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    boot_d  = 1'b0;
                    // The settle that follows reset is not a switch
                    if (!boot_q) begin
                        count_d = count_q + 1'b1;
                    end
                end else if (cnt_q != c_SETTLE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && I_settings_wr) begin
            pend_data_d = I_settings_data;
            pend_vld_d  = 1'b1;
            if (pend_vld_q) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            state_q     <= ST_SETTLE;
            cnt_q       <= '0;
            settings_q  <= RESET_SETTINGS;
            target_q    <= RESET_SETTINGS;
            pend_vld_q  <= 1'b0;
            pend_data_q <= '0;
            overrun_q   <= 1'b0;
            count_q     <= '0;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settings_q  <= settings_d;
            target_q    <= target_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            overrun_q   <= overrun_d;
            count_q     <= count_d;
            boot_q      <= boot_d;
        end
    end

    assign O_clock_settings = settings_q;
    assign O_target_reset   = (state_q != ST_IDLE);
    assign O_busy           = (state_q != ST_IDLE);
    assign O_overrun        = overrun_q;
    assign O_switch_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_select_ctrl.sv
// ============================================================================
// Module      : tb_clock_select_ctrl
// Description : Directed, table-driven bench for clock_select_ctrl
//               (PRE=4, SETTLE=8, 2-bit switch counter to exercise wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_select_ctrl;

    logic       usb_clk;
    logic       reset;
    logic       I_settings_wr;
    logic [2:0] I_settings_data;
    logic       I_clear;
    logic [2:0] O_clock_settings;
    logic       O_target_reset;
    logic       O_busy;
    logic       O_overrun;
    logic [1:0] O_switch_count;
`ifdef CLKSEL_ALIVE_CHECK_EN
    logic       I_ext_clk_toggle;
    logic       O_alive_timeout;
    logic       tog_en;
`endif

    int n_vec;
    int n_err;

    clock_select_ctrl #(
        .PRE_CYCLES     (4),
        .SETTLE_CYCLES  (8),
        .RESET_SETTINGS (3'b000),
`ifdef CLKSEL_ALIVE_CHECK_EN
        .ALIVE_EDGES    (4),
        .ALIVE_TIMEOUT  (32),
`endif
        .CNT_WIDTH      (2)
    ) dut (
        .usb_clk          (usb_clk),
        .reset            (reset),
        .I_settings_wr    (I_settings_wr),
        .I_settings_data  (I_settings_data),
        .I_clear          (I_clear),
`ifdef CLKSEL_ALIVE_CHECK_EN
        .I_ext_clk_toggle (I_ext_clk_toggle),
        .O_alive_timeout  (O_alive_timeout),
`endif
        .O_clock_settings (O_clock_settings),
        .O_target_reset   (O_target_reset),
        .O_busy           (O_busy),
        .O_overrun        (O_overrun),
        .O_switch_count   (O_switch_count)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    typedef struct {
        int         rep;
        logic       wr;
        logic [2:0] data;
        logic       clr;
        logic [2:0] e_set;
        logic       e_busy;
        logic       e_ovr;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int rep, logic wr, logic [2:0] d, logic clr,
                               logic [2:0] es, logic eb, logic eo, logic [1:0] ec);
        vec_t t;
        t.rep = rep; t.wr = wr; t.data = d; t.clr = clr;
        t.e_set = es; t.e_busy = eb; t.e_ovr = eo; t.e_cnt = ec;
        return t;
    endfunction

    // Inputs change on the falling edge; outputs are read one falling edge later
    task automatic step(input logic wr, input logic [2:0] d, input logic clr);
        I_settings_wr   = wr;
        I_settings_data = d;
        I_clear         = clr;
`ifdef CLKSEL_ALIVE_CHECK_EN
        if (tog_en) I_ext_clk_toggle = ~I_ext_clk_toggle;
`endif
        @(posedge usb_clk);
        @(negedge usb_clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic measure_hold(input string name);
        int n;
        n = 0;
        reset = 1'b0;
        while (O_target_reset && n < 40) begin
            n++;
            step(1'b0, 3'b000, 1'b0);
        end
        check(name, n, 8);
    endtask

    initial begin
        int n;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        I_settings_wr = 1'b0;
        I_settings_data = 3'b000;
        I_clear = 1'b0;
`ifdef CLKSEL_ALIVE_CHECK_EN
        I_ext_clk_toggle = 1'b0;
        tog_en = 1'b1;
`endif

        // rep, wr, data, clr  ->  settings, busy/target_reset, overrun, count
        tbl.push_back(v(3, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(v(1, 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0)); // same value dropped
        tbl.push_back(v(2, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0));
        tbl.push_back(v(1, 1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0)); // T+1
        tbl.push_back(v(3, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0)); // T+2..4
        tbl.push_back(v(8, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 2'd0)); // T+5..12
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1)); // T+13
        tbl.push_back(v(1, 1'b1, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1));
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 2'd1));
        tbl.push_back(v(1, 1'b1, 3'b011, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1)); // T+1
        tbl.push_back(v(1, 1'b1, 3'b010, 1'b0, 3'b001, 1'b1, 1'b0, 2'd1)); // pending 010
        tbl.push_back(v(1, 1'b1, 3'b100, 1'b1, 3'b001, 1'b1, 1'b1, 2'd1)); // overrun beats clear
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b001, 1'b1, 1'b1, 2'd1));
        tbl.push_back(v(8, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1, 1'b1, 2'd1));
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b011, 1'b0, 1'b1, 2'd2)); // single IDLE gap
        tbl.push_back(v(4, 1'b0, 3'b000, 1'b0, 3'b011, 1'b1, 1'b1, 2'd2));
        tbl.push_back(v(8, 1'b0, 3'b000, 1'b0, 3'b100, 1'b1, 1'b1, 2'd2));
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b100, 1'b0, 1'b1, 2'd3));
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 2'd3)); // clear
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 2'd3));
        tbl.push_back(v(1, 1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 2'd3)); // T+1
        tbl.push_back(v(2, 1'b0, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 2'd3));
        tbl.push_back(v(1, 1'b1, 3'b010, 1'b0, 3'b100, 1'b1, 1'b0, 2'd3)); // pending, no overrun
        tbl.push_back(v(8, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 2'd3));
        tbl.push_back(v(1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0)); // count wraps
        tbl.push_back(v(1, 1'b1, 3'b110, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0)); // write beats pending
        tbl.push_back(v(3, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0));
        tbl.push_back(v(8, 1'b0, 3'b000, 1'b0, 3'b110, 1'b1, 1'b0, 2'd0));
        tbl.push_back(v(2, 1'b0, 3'b000, 1'b0, 3'b110, 1'b0, 1'b0, 2'd1)); // pending discarded

        @(negedge usb_clk);
        repeat (3) step(1'b0, 3'b000, 1'b0);
        check("rst.settings", O_clock_settings, 3'b000);
        check("rst.target_reset", O_target_reset, 1'b1);
        check("rst.busy", O_busy, 1'b1);
        check("rst.overrun", O_overrun, 1'b0);
        check("rst.count", O_switch_count, 2'd0);
        measure_hold("boot.hold_cycles");
        check("boot.settings", O_clock_settings, 3'b000);
        check("boot.count", O_switch_count, 2'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                step(tbl[i].wr, tbl[i].data, tbl[i].clr);
                check($sformatf("v%0d.%0d settings", i, r), O_clock_settings, tbl[i].e_set);
                check($sformatf("v%0d.%0d target_reset", i, r), O_target_reset, tbl[i].e_busy);
                check($sformatf("v%0d.%0d busy", i, r), O_busy, tbl[i].e_busy);
                check($sformatf("v%0d.%0d overrun", i, r), O_overrun, tbl[i].e_ovr);
                check($sformatf("v%0d.%0d count", i, r), O_switch_count, tbl[i].e_cnt);
            end
        end

        // Reset in the middle of SETTLE with a pending request and overrun
        step(1'b1, 3'b011, 1'b0);
        repeat (4) step(1'b0, 3'b000, 1'b0);
        check("mid.settings", O_clock_settings, 3'b011);
        check("mid.busy", O_busy, 1'b1);
        step(1'b1, 3'b101, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        check("mid.overrun", O_overrun, 1'b1);
        reset = 1'b1;
        step(1'b0, 3'b000, 1'b0);
        check("mrst.settings", O_clock_settings, 3'b000);
        check("mrst.target_reset", O_target_reset, 1'b1);
        check("mrst.busy", O_busy, 1'b1);
        check("mrst.overrun", O_overrun, 1'b0);
        check("mrst.count", O_switch_count, 2'd0);
        measure_hold("mrst.hold_cycles");
        check("mrst.count_after", O_switch_count, 2'd0);
        repeat (3) step(1'b0, 3'b000, 1'b0);
        check("mrst.no_followon", O_busy, 1'b0);
        check("mrst.settings_after", O_clock_settings, 3'b000);

`ifdef CLKSEL_ALIVE_CHECK_EN
        // Dead ext clock: SETTLE is released by the 32-cycle timeout
        tog_en = 1'b0;
        repeat (4) step(1'b0, 3'b000, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        n = 0;
        while (O_busy && n < 100) begin
            n++;
            step(1'b0, 3'b000, 1'b0);
        end
        check("alive.busy_cycles", n, 36);
        check("alive.timeout", O_alive_timeout, 1'b1);
        check("alive.settings", O_clock_settings, 3'b001);
        check("alive.count", O_switch_count, 2'd1);
        step(1'b0, 3'b000, 1'b1);
        check("alive.cleared", O_alive_timeout, 1'b0);
`else
        n = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
